// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and
// the bit-counter width helper.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // Width of a counter that indexes bits 0..width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell from the arithmetic library.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH cycles,
// LSB first, with a registered carry and a start/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state;
    state_e           next_state;
    logic             accept;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_cout;
    logic             cout_r;
    logic             ovf_r;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (last_bit) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                // Subtraction is a + ~b + 1; the +1 rides in on the carry.
                a_sr  <= a;
                b_sr  <= sub ? ~b : b;
                carry <= sub | cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                carry  <= fa_cout;
                cnt    <= cnt + CW'(1);
                if (last_bit) begin
                    // carry still holds the carry into the MSB here.
                    cout_r <= fa_cout;
                    ovf_r  <= carry ^ fa_cout;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = sum_sr;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, handshake
// and reset corner sequences, and randomized operations against a model.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] va;
        logic [7:0] vb;
        logic       vcin;
        logic       vsub;
        logic [7:0] esum;
        logic       ecout;
        logic       eovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic ref_model(input logic [7:0] ra, input logic [7:0] rb, input logic rcin,
                             input logic rsub, output logic [7:0] rs, output logic rco,
                             output logic rov);
        int ua;
        int ub;
        int sa;
        int sb;
        int u;
        int sr;
        ua = int'(ra);
        ub = int'(rb);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (rsub) begin
            u   = (ua - ub + 256) % 256;
            rco = (ua >= ub);
            sr  = sa - sb;
        end else begin
            u   = ua + ub + int'(rcin);
            rco = (u >= 256);
            u   = u % 256;
            sr  = sa + sb + int'(rcin);
        end
        rs  = u[7:0];
        rov = (sr > 127) || (sr < -128);
    endtask

    task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_val,
                          input logic tcin, input logic tsub, input logic [7:0] es,
                          input logic ec, input logic eo);
        int n;
        int nbusy;
        a     = ta;
        b     = tb_val;
        cin   = tcin;
        sub   = tsub;
        start = 1'b1;
        tick();
        start = 1'b0;
        n     = 0;
        nbusy = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) nbusy++;
            tick();
            n++;
        end
        check({nm, " latency"}, n, WIDTH);
        check({nm, " busy_cycles"}, nbusy, WIDTH);
        check({nm, " busy_at_done"}, busy, 0);
        check({nm, " sum"}, sum, es);
        check({nm, " cout"}, cout, ec);
        check({nm, " ovf"}, ovf, eo);
        tick();
        check({nm, " done_width"}, done, 0);
        check({nm, " sum_hold"}, sum, es);
    endtask

    initial begin
        int          n;
        int          seen;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rc;
        logic        rsb;
        logic [7:0]  es;
        logic        ec;
        logic        eo;

        vecs[0] = '{"add_3c_05",  8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{"add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"add_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{"sub_05_07",  8'h05, 8'h07, 1'bx, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{"sub_80_01",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{"add_cin",    8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{"add_80_80",  8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{"sub_55_55",  8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        sub   = 1'b0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
        check("reset ovf", ovf, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle busy", busy, 0);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
                   vecs[i].esum, vecs[i].ecout, vecs[i].eovf);

        // start during RUN is ignored
        a = 8'h3C; b = 8'h05; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
        check("ignore busy", busy, 1);
        wait_done(n);
        check("ignore latency", n, 5);
        check("ignore sum", sum, 8'h41);
        check("ignore cout", cout, 0);
        check("ignore ovf", ovf, 0);
        tick();

        // back-to-back start held in the DONE cycle
        a = 8'h3C; b = 8'h05; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("b2b first latency", n, WIDTH);
        check("b2b first sum", sum, 8'h41);
        a = 8'h10; b = 8'h20; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b done drops", done, 0);
        check("b2b busy", busy, 1);
        wait_done(n);
        check("b2b edges", n + 1, WIDTH + 1);
        check("b2b sum", sum, 8'h30);
        check("b2b cout", cout, 0);
        tick();

        // reset in the middle of a run
        run_op("pre_reset", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        a = 8'h3C; b = 8'h05; cin = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst sum", sum, 0);
        check("midrst cout", cout, 0);
        check("midrst ovf", ovf, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        check("midrst no_done", seen, 0);
        run_op("post_reset", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);

        // randomized operations with random idle gaps
        for (int i = 0; i < 1000; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            rsb = 1'($urandom);
            ref_model(ra, rb, rc, rsb, es, ec, eo);
            run_op("rand", ra, rb, rc, rsb, es, ec, eo);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder/subtractor. A single one-bit full-adder cell is time-multiplexed over WIDTH cycles, LSB first, with a registered carry between bits. The block owns the operand shift registers, the carry flop, the bit counter and the start/done handshake. It serves as the area-minimal alternative to the ripple-carry adder in the arithmetic library.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when state is IDLE or DONE
a  input  WIDTH  operand A; latched on accepted start
b  input  WIDTH  operand B; latched on accepted start
cin  input  1  carry-in for add; latched on accepted start; ignored when sub=1
sub  input  1  1 = compute a-b (b inverted, carry-in forced 1); latched on accepted start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result; stable from done until next accepted start
cout  output  1  final carry-out; for sub, 1 = no borrow
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-RUN): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; counter=0; carry=0. rst has priority over start.
- States:
  - IDLE: start=1 -> latch a, b_eff, carry=c0; counter=0; -> RUN. start=0 -> stay in IDLE.
  - RUN: busy=1. Each edge:
    - Full-adder inputs are a_sr[0], b_sr[0], carry.
    - Sum bit shifts into sum MSB; sum shifts right; a_sr and b_sr shift right.
    - carry <= cell cout; counter++.
    - On the edge where counter==WIDTH-1: capture cout and ovf (carry into MSB XOR cell cout); -> DONE.
  - DONE: done=1 for exactly one cycle. start=1 -> accept as in IDLE and go to RUN (back-to-back; done still drops). Otherwise -> IDLE.
- Operand rules: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- start while in RUN is ignored. Latched operands, counter and carry are unaffected.
- Latency: start accepted at edge E0. Bits are processed at edges E1..E_WIDTH. done is high in the cycle after E_WIDTH. Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- sum, cout and ovf hold their value in IDLE and DONE. During RUN, sum holds partial bits and is not valid for consumers.
- Counter width is clog2(WIDTH). It never wraps in normal operation because the DONE transition occurs at WIDTH-1.
- Arithmetic is modulo 2^WIDTH. cout/ovf semantics are as above for both add and sub.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding localparams: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - counter-width helper (clog2).
- Exactly one sub-module: the team's existing one-bit full_adder cell (ports a, b, cin, sum, cout), instantiated once as the datapath.
- All sequencing, shift registers and flags live in serial_adder_ctrl.

Test Plan (WIDTH=8):
- Add: a=8'h3C, b=8'h05, cin=0, sub=0, start at E0 -> busy high for E1..E8; done pulses the cycle after E8; sum=8'h41, cout=0, ovf=0.
- Carry out: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- Subtract: a=8'h05, b=8'h07, sub=1, cin=1'bx -> sum=8'hFE, cout=0 (borrow), ovf=0. Also a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
- Handshake:
  - start pulsed at E3 of a RUN with different operands -> ignored; the first result is unchanged.
  - start held high in the DONE cycle with a=8'h10, b=8'h20 -> accepted; second done exactly 9 edges later with sum=8'h30.
- Reset mid-op: rst=1 at E4 of a RUN -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse follows. A fresh start afterwards yields the correct result.
- Random: 1000 random a/b/cin/sub vectors with random idle gaps -> each sum/cout/ovf matches the reference model, and done is exactly one cycle wide.
